// File: rtl/shift_arbiter_pkg.sv
// Shared types and helpers for the two-requester shift sequencer.
package shift_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  // Requester indices.
  localparam logic IDX_REQ0 = 1'b0;
  localparam logic IDX_REQ1 = 1'b1;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // One captured shift request.
  typedef struct packed {
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] shift;
    logic              lnr;
  } shift_op_t;

  // One-hot requester vector {req1, req0} for an index.
  function automatic logic [1:0] idx_onehot(input logic idx);
    return (idx == IDX_REQ1) ? 2'b10 : 2'b01;
  endfunction

  // Mirror a word so a single left-shift network also serves right shifts.
  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// 32-bit logarithmic barrel shifter, zero-fill in both directions.
// Shift amounts with any bit above bit 4 set produce zero.
module barrel_shifter
  import shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] shift,
  input  logic              lnr,
  output logic [DATA_W-1:0] result
);

  logic [SHAMT_W:0][DATA_W-1:0] stg;
  logic                         out_of_range;

  // Right shifts reuse the left-shift network on a bit-reversed operand.
  assign stg[0]       = lnr ? operand : bit_reverse(operand);
  assign out_of_range = |shift[DATA_W-1:SHAMT_W];

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int S = 1 << i;
    assign stg[i+1] = shift[i] ? {stg[i][DATA_W-1-S:0], {S{1'b0}}} : stg[i];
  end

  // Undo the reversal for right shifts and clamp oversized amounts to zero.
  always_comb begin
    result = '0;
    if (!out_of_range) begin
      result = lnr ? stg[SHAMT_W] : bit_reverse(stg[SHAMT_W]);
    end
  end

endmodule

// File: rtl/shift_arbiter_rr_arbiter2.sv
// Two-way round-robin winner selection; purely combinational.
module rr_arbiter2
  import shift_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic valid
);

  // A lone request wins outright; on a tie the index that did not win last time goes.
  always_comb begin
    valid  = req0 | req1;
    winner = IDX_REQ0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = IDX_REQ1;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between two requesters, round-robin, one
// transaction in flight, registered result held until the owner acknowledges.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for a request; grant + capture operands on entry to EXEC
//   EXEC    | shifter driven from capture regs; result registered at cycle end
//   HOLD    | DONE to owner, RESULT stable until owner's ACK
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0,
  input  logic                 REQ1,
  input  logic [DATA_W-1:0]    OPERAND0,
  input  logic [DATA_W-1:0]    OPERAND1,
  input  logic [DATA_W-1:0]    SHIFT0,
  input  logic [DATA_W-1:0]    SHIFT1,
  input  logic                 LNR0,
  input  logic                 LNR1,
  input  logic                 ACK0,
  input  logic                 ACK1,
  output logic                 GNT0,
  output logic                 GNT1,
  output logic                 DONE0,
  output logic                 DONE1,
  output logic [DATA_W-1:0]    RESULT,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] OP_COUNT
);

  state_t            state;
  state_t            state_nxt;
  logic              last;
  logic              owner;
  shift_op_t         cap;
  shift_op_t         win_op;
  logic              win_idx;
  logic              win_valid;
  logic [DATA_W-1:0] shift_out;
  logic              ack_owner;
  logic              grant;
  logic              load_result;
  logic              complete;
  logic [1:0]        done_nxt;

  rr_arbiter2 u_arb (
    .req0   (REQ0),
    .req1   (REQ1),
    .last   (last),
    .winner (win_idx),
    .valid  (win_valid)
  );

  barrel_shifter u_shift (
    .operand (cap.operand),
    .shift   (cap.shift),
    .lnr     (cap.lnr),
    .result  (shift_out)
  );

  // Only the current owner's acknowledge can release a transaction.
  assign ack_owner = (owner == IDX_REQ1) ? ACK1 : ACK0;

  // Operand set of whichever requester the arbiter picked.
  always_comb begin
    win_op = '0;
    if (win_idx == IDX_REQ1) begin
      win_op.operand = OPERAND1;
      win_op.shift   = SHIFT1;
      win_op.lnr     = LNR1;
    end else begin
      win_op.operand = OPERAND0;
      win_op.shift   = SHIFT0;
      win_op.lnr     = LNR0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (win_valid) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_HOLD;
      ST_HOLD: if (ack_owner) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control strobes and the next DONE vector.
  always_comb begin
    grant       = 1'b0;
    load_result = 1'b0;
    complete    = 1'b0;
    done_nxt    = {DONE1, DONE0};
    case (state)
      ST_IDLE: grant = win_valid;
      ST_EXEC: begin
        load_result = 1'b1;
        done_nxt    = idx_onehot(owner);
      end
      ST_HOLD: begin
        if (ack_owner) begin
          complete = 1'b1;
          done_nxt = 2'b00;
        end
      end
      default: done_nxt = 2'b00;
    endcase
  end

  // Capture operands, owner and round-robin history on every grant.
  // LAST resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cap   <= '0;
      owner <= IDX_REQ0;
      last  <= IDX_REQ1;
    end else if (grant) begin
      cap   <= win_op;
      owner <= win_idx;
      last  <= win_idx;
    end
  end

  // Registered outputs; nothing here is a combinational path from inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
      RESULT   <= '0;
      BUSY     <= 1'b0;
      OP_COUNT <= '0;
    end else begin
      GNT0  <= grant && (win_idx == IDX_REQ0);
      GNT1  <= grant && (win_idx == IDX_REQ1);
      DONE0 <= done_nxt[0];
      DONE1 <= done_nxt[1];
      BUSY  <= (state_nxt != ST_IDLE);
      if (load_result) begin
        RESULT <= shift_out;
      end
      if (complete) begin
        OP_COUNT <= OP_COUNT + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a vector table of single-requester
// transactions plus hand-written tie, alternation, ignored-ACK, reset and
// counter-wrap sequences. A second instance with a 2-bit counter shares stimulus.
module tb_shift_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [31:0] operand0, operand1, shift0, shift1;
  logic        lnr0, lnr1, ack0, ack1;

  logic        gnt0, gnt1, done0, done1, busy;
  logic [31:0] result;
  logic [15:0] op_count;

  logic        gnt0_b, gnt1_b, done0_b, done1_b, busy_b;
  logic [31:0] result_b;
  logic [1:0]  op_count_b;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count;
  logic model_last;

  typedef struct {
    logic        idx;
    logic [31:0] op;
    logic [31:0] sh;
    logic        lnr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  shift_arbiter #(.CNT_WIDTH(16)) dut (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1),
    .OPERAND0(operand0), .OPERAND1(operand1), .SHIFT0(shift0), .SHIFT1(shift1),
    .LNR0(lnr0), .LNR1(lnr1), .ACK0(ack0), .ACK1(ack1),
    .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1),
    .RESULT(result), .BUSY(busy), .OP_COUNT(op_count)
  );

  shift_arbiter #(.CNT_WIDTH(2)) dut_w2 (
    .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1),
    .OPERAND0(operand0), .OPERAND1(operand1), .SHIFT0(shift0), .SHIFT1(shift1),
    .LNR0(lnr0), .LNR1(lnr1), .ACK0(ack0), .ACK1(ack1),
    .GNT0(gnt0_b), .GNT1(gnt1_b), .DONE0(done0_b), .DONE1(done1_b),
    .RESULT(result_b), .BUSY(busy_b), .OP_COUNT(op_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot32(input logic idx);
    return idx ? 32'h2 : 32'h1;
  endfunction

  task automatic check_counts();
    check("op_count", {16'h0, op_count}, exp_count & 32'hFFFF);
    check("op_count_w2", {30'h0, op_count_b}, exp_count & 32'h3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 0; req1 = 0; ack0 = 0; ack1 = 0;
    operand0 = '0; operand1 = '0; shift0 = '0; shift1 = '0; lnr0 = 0; lnr1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_count  = 0;
    model_last = 1'b1;
  endtask

  task automatic set_ops(input logic idx, input logic [31:0] op, input logic [31:0] sh,
                         input logic lnr);
    if (idx) begin operand1 = op; shift1 = sh; lnr1 = lnr; end
    else     begin operand0 = op; shift0 = sh; lnr0 = lnr; end
  endtask

  // One uncontended transaction with fixed latency: GNT, then DONE/RESULT, then ACK.
  task automatic run_txn(input vec_t v);
    set_ops(v.idx, v.op, v.sh, v.lnr);
    if (v.idx) req1 = 1'b1; else req0 = 1'b1;
    @(negedge clk);
    check("gnt", {30'h0, gnt1, gnt0}, onehot32(v.idx));
    check("busy_exec", {31'h0, busy}, 32'h1);
    check("done_exec", {30'h0, done1, done0}, 32'h0);
    model_last = v.idx;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    check("done_hold", {30'h0, done1, done0}, onehot32(v.idx));
    check("gnt_hold", {30'h0, gnt1, gnt0}, 32'h0);
    check("result", result, v.exp);
    check("result_w2", result_b, v.exp);
    if (v.idx) ack1 = 1'b1; else ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0; ack1 = 1'b0;
    exp_count++;
    check("done_after_ack", {30'h0, done1, done0}, 32'h0);
    check("busy_after_ack", {31'h0, busy}, 32'h0);
    check_counts();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_00F0, 32'd4,         1'b1, 32'h0000_0F00};
    vecs[1]  = '{1'b1, 32'h8000_0000, 32'd31,        1'b0, 32'h0000_0001};
    vecs[2]  = '{1'b0, 32'h1234_5678, 32'd32,        1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'hDEAD_BEEF, 32'd0,         1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'hDEAD_BEEF, 32'd0,         1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 32'hF000_0001, 32'd1,         1'b0, 32'h7800_0000};
    vecs[7]  = '{1'b1, 32'h0000_000F, 32'd31,        1'b1, 32'h8000_0000};
    vecs[8]  = '{1'b0, 32'hA5A5_A5A5, 32'd16,        1'b1, 32'hA5A5_0000};
    vecs[9]  = '{1'b1, 32'hA5A5_A5A5, 32'd8,         1'b0, 32'h00A5_A5A5};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'h21,        1'b1, 32'h0000_0000};
    vecs[11] = '{1'b1, 32'h1234_5678, 32'h100,       1'b0, 32'h0000_0000};

    // Reset values, sampled while reset is still held.
    rst = 1'b1;
    req0 = 0; req1 = 0; ack0 = 0; ack1 = 0;
    operand0 = '0; operand1 = '0; shift0 = '0; shift1 = '0; lnr0 = 0; lnr1 = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", {30'h0, gnt1, gnt0}, 32'h0);
    check("rst_done", {30'h0, done1, done0}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    exp_count = 0;
    check_counts();
    do_reset();

    // First tie after reset goes to requester 0; REQ1 held, served next.
    set_ops(1'b0, 32'h0000_00F0, 32'd4, 1'b1);
    set_ops(1'b1, 32'h8000_0000, 32'd31, 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    check("tie_gnt", {30'h0, gnt1, gnt0}, 32'h1);
    check("tie_gnt_w2", {30'h0, gnt1_b, gnt0_b}, 32'h1);
    req0 = 1'b0;
    @(negedge clk);
    check("tie_done0", {30'h0, done1, done0}, 32'h1);
    check("tie_result0", result, 32'h0000_0F00);
    // Non-owner ACK must be ignored.
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    check("ign_ack_done", {30'h0, done1, done0}, 32'h1);
    check("ign_ack_done_w2", {30'h0, done1_b, done0_b}, 32'h1);
    check("ign_ack_result", result, 32'h0000_0F00);
    check("ign_ack_gnt", {30'h0, gnt1, gnt0}, 32'h0);
    check_counts();
    ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    exp_count++;
    check("tie_release", {30'h0, done1, done0}, 32'h0);
    check_counts();
    @(negedge clk);
    check("tie_gnt1", {30'h0, gnt1, gnt0}, 32'h2);
    req1 = 1'b0;
    @(negedge clk);
    check("tie_done1", {30'h0, done1, done0}, 32'h2);
    check("tie_result1", result, 32'h0000_0001);
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    exp_count++;
    check("tie_release1", {30'h0, done1, done0}, 32'h0);
    check("busy_idle", {31'h0, busy_b}, 32'h0);
    check_counts();
    model_last = 1'b1;

    // Table of uncontended transactions.
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i]);
    end

    // Both requesters held high: grants must alternate starting opposite LAST.
    set_ops(1'b0, 32'h0000_0001, 32'd1, 1'b1);
    set_ops(1'b1, 32'h0000_0100, 32'd4, 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      int   cyc;
      logic who;
      logic exp_who;
      cyc = 0;
      exp_who = ~model_last;
      @(negedge clk);
      while (!(gnt0 | gnt1) && cyc < 8) begin
        @(negedge clk);
        cyc++;
      end
      check("alt_gnt", {30'h0, gnt1, gnt0}, onehot32(exp_who));
      check("alt_order", {31'h0, exp_who}, {31'h0, t[0]});
      who = gnt1;
      model_last = exp_who;
      @(negedge clk);
      check("alt_done", {30'h0, done1, done0}, onehot32(exp_who));
      check("alt_result", result, exp_who ? 32'h0000_0010 : 32'h0000_0002);
      if (who) ack1 = 1'b1; else ack0 = 1'b1;
      @(negedge clk);
      ack0 = 1'b0; ack1 = 1'b0;
      exp_count++;
      check_counts();
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Reset while in EXEC aborts everything.
    set_ops(1'b0, 32'h0000_0003, 32'd2, 1'b1);
    req0 = 1'b1;
    @(negedge clk);
    check("mid_gnt", {30'h0, gnt1, gnt0}, 32'h1);
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    exp_count = 0;
    check("mid_rst_gnt", {30'h0, gnt1, gnt0}, 32'h0);
    check("mid_rst_done", {30'h0, done1, done0}, 32'h0);
    check("mid_rst_result", result, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check_counts();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", {30'h0, done1, done0}, 32'h0);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    model_last = 1'b1;

    // Counter wrap on the 2-bit instance: five completions leave 1.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i]);
    end
    check("wrap_w2", {30'h0, op_count_b}, 32'h1);
    check("wrap_w16", {16'h0, op_count}, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
